// File: rtl/seq_detect_ctrl.sv
// Run controller for a serial pattern detector: arms on start, counts pattern hits, ends on target or timeout.
// Define SEQ_CTRL_STICKY_EN to make done/timeout hold high until the next accepted start or abort.
module seq_detect_ctrl #(
    parameter int PAT_W = 5,
    parameter int CNT_W = 8,
    parameter int TMO_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern_cfg,
    input  logic             overlap,
    input  logic [CNT_W-1:0] match_target,
    input  logic [TMO_W-1:0] timeout_cyc,
    input  logic             in_valid,
    input  logic             in,
    output logic             busy,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             done,
    output logic             timeout
);

    localparam int BW = $clog2(PAT_W + 1);

    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [PAT_W-1:0] shift_q, pat_q, shift_new;
    logic [BW-1:0]    bits_q, bits_inc;
    logic             ovl_q;
    logic [CNT_W-1:0] tgt_q, cnt_q, cnt_new;
    logic [TMO_W-1:0] tmo_q, timer_q, timer_inc;
    logic             out_q, done_q, tmo_flag_q;
    logic             hit, reach, expire, accept, end_done, end_tmo;

    // The end conditions look at the count including a hit in this cycle,
    // so a hit that lands on the timeout cycle can still finish the run.
    assign shift_new = {shift_q[PAT_W-2:0], in};
    assign bits_inc  = (bits_q == BW'(PAT_W)) ? bits_q : bits_q + 1'b1;
    assign hit       = (state == RUN) && in_valid && (bits_inc == BW'(PAT_W)) && (shift_new == pat_q);
    assign cnt_new   = (hit && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
    assign timer_inc = timer_q + 1'b1;
    assign reach     = (cnt_new >= tgt_q);
    assign expire    = (tmo_q != '0) && (timer_inc == tmo_q);
    assign accept    = (state == IDLE) && start && !abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        end_done  = 1'b0;
        end_tmo   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = ARM;
                end
            end
            ARM: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (match_target == '0) begin
                    state_nxt = DONE;
                    end_done  = 1'b1;
                end else begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (reach) begin
                    state_nxt = DONE;
                    end_done  = 1'b1;
                end else if (expire) begin
                    state_nxt = DONE;
                    end_tmo   = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q   <= '0;
            ovl_q   <= 1'b0;
            tgt_q   <= '0;
            tmo_q   <= '0;
            shift_q <= '0;
            bits_q  <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
            out_q   <= 1'b0;
        end else begin
            out_q <= hit && !abort;
            if (state == ARM) begin
                pat_q   <= pattern_cfg;
                ovl_q   <= overlap;
                tgt_q   <= match_target;
                tmo_q   <= timeout_cyc;
                shift_q <= '0;
                bits_q  <= '0;
                cnt_q   <= '0;
                timer_q <= '0;
            end else if ((state == RUN) && !abort) begin
                timer_q <= timer_inc;
                cnt_q   <= cnt_new;
                if (in_valid) begin
                    shift_q <= shift_new;
                    // Non-overlapping mode forgets the history so the next hit needs a full fresh pattern.
                    bits_q  <= (hit && !ovl_q) ? '0 : bits_inc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q     <= 1'b0;
            tmo_flag_q <= 1'b0;
        end else begin
`ifdef SEQ_CTRL_STICKY_EN
            if (accept || abort) begin
                done_q     <= 1'b0;
                tmo_flag_q <= 1'b0;
            end
            if (end_done) begin
                done_q <= 1'b1;
            end
            if (end_tmo) begin
                tmo_flag_q <= 1'b1;
            end
`else
            done_q     <= end_done;
            tmo_flag_q <= end_tmo;
`endif
        end
    end

    assign busy      = (state == ARM) || (state == RUN);
    assign out       = out_q;
    assign match_cnt = cnt_q;
    assign done      = done_q;
    assign timeout   = tmo_flag_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: table of directed runs, hand-written reset/sticky sequences,
// and randomized runs checked cycle by cycle against a bit-history reference model.
module tb_seq_detect_ctrl;

    localparam int PAT_W = 5;
    localparam int CNT_W = 8;
    localparam int TMO_W = 16;
`ifdef SEQ_CTRL_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, start, abort, overlap, in_valid, din;
    logic [PAT_W-1:0] pattern_cfg;
    logic [CNT_W-1:0] match_target;
    logic [TMO_W-1:0] timeout_cyc;
    logic             busy, dout, done, timeout;
    logic [CNT_W-1:0] match_cnt;

    int   total = 0;
    int   bad   = 0;
    logic stim_v [0:255];
    logic stim_b [0:255];
    int   abort_at = 0;
    int   start_at = 0;

    typedef struct {
        string            name;
        logic [PAT_W-1:0] pat;
        logic             ovl;
        logic [CNT_W-1:0] tgt;
        logic [TMO_W-1:0] tmo;
        logic [31:0]      valid;
        logic [31:0]      bits;
        int               abort_at;
        int               start_at;
        logic [7:0]       exp_hits;
        logic [CNT_W-1:0] exp_cnt;
        logic             exp_done;
        logic             exp_tmo;
        int               exp_len;
    } vec_t;

    vec_t vecs [10];

    seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .pattern_cfg  (pattern_cfg),
        .overlap      (overlap),
        .match_target (match_target),
        .timeout_cyc  (timeout_cyc),
        .in_valid     (in_valid),
        .in           (din),
        .busy         (busy),
        .out          (dout),
        .match_cnt    (match_cnt),
        .done         (done),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] pack_obs();
        return {busy, dout, done, timeout, match_cnt};
    endfunction

    task automatic apply_stimulus(input logic v, input logic b, input logic s, input logic a);
        in_valid = v;
        din      = b;
        start    = s;
        abort    = a;
        tick();
    endtask

    task automatic load_stim(input logic [31:0] v, input logic [31:0] b);
        for (int j = 0; j < 256; j++) begin
            stim_v[j] = 1'b0;
            stim_b[j] = 1'b0;
            if (j < 32) begin
                stim_v[j] = v[j];
                stim_b[j] = b[j];
            end
        end
    endtask

    // One complete run. stim_v/stim_b hold the bit offered in each RUN cycle; the model keeps the
    // list of accepted bits and looks for the pattern in its last PAT_W entries.
    task automatic run_stream(input logic [PAT_W-1:0] pat, input logic ovl, input logic [CNT_W-1:0] tgt,
                              input logic [TMO_W-1:0] tmo, input int ncyc, output int hits,
                              output logic [CNT_W-1:0] cnt_o, output logic d_o, output logic t_o,
                              output int len_o);
        logic             hist [$];
        int               fresh;
        logic [CNT_W-1:0] ecnt;
        logic [PAT_W-1:0] win;
        logic             hit, ed, et, ended;
        hits = 0; cnt_o = '0; d_o = 1'b0; t_o = 1'b0; len_o = -1;
        fresh = 0; ecnt = '0; ed = 1'b0; et = 1'b0; ended = 1'b0;
        pattern_cfg  = pat;
        overlap      = ovl;
        match_target = tgt;
        timeout_cyc  = tmo;
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        check_output("arm", {28'd0, busy, dout, done, timeout}, 32'h8);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        pattern_cfg  = PAT_W'($urandom);
        overlap      = 1'($urandom);
        match_target = CNT_W'($urandom);
        timeout_cyc  = TMO_W'($urandom);
        if (tgt == '0) begin
            ed = 1'b1; ended = 1'b1; len_o = 0;
            check_output("zero_target", {20'd0, pack_obs()}, {20'd0, 4'b0010, 8'd0});
            cnt_o = match_cnt; d_o = done; t_o = timeout;
        end else begin
            check_output("run_entry", {20'd0, pack_obs()}, {20'd0, 4'b1000, 8'd0});
        end
        for (int k = 1; k <= ncyc && !ended; k++) begin
            if (k == abort_at || k == ncyc) begin
                apply_stimulus(stim_v[k-1], stim_b[k-1], k == start_at, 1'b1);
                check_output("abort", {28'd0, busy, dout, done, timeout}, 32'h0);
                ended = 1'b1;
            end else begin
                apply_stimulus(stim_v[k-1], stim_b[k-1], k == start_at, 1'b0);
                hit = 1'b0;
                if (stim_v[k-1]) begin
                    hist.push_back(stim_b[k-1]);
                    if (fresh < PAT_W) fresh++;
                    if (fresh >= PAT_W) begin
                        win = '0;
                        for (int j = hist.size() - PAT_W; j < hist.size(); j++) win = win * 2 + PAT_W'(hist[j]);
                        hit = (win == pat);
                    end
                    if (hit && !ovl) fresh = 0;
                end
                if (hit && ecnt != '1) ecnt++;
                ed = (ecnt >= tgt);
                et = !ed && (tmo != '0) && (int'(tmo) == k);
                ended = ed || et;
                if (ended) len_o = k;
                check_output($sformatf("cycle%0d", k), {20'd0, pack_obs()}, {20'd0, !ended, hit, ed, et, ecnt});
                hits += int'(dout);
                cnt_o = match_cnt; d_o = done; t_o = timeout;
            end
        end
        if (len_o >= 0) begin
            apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
            check_output("back_to_idle", {20'd0, pack_obs()},
                         {20'd0, 1'b0, 1'b0, STICKY & ed, STICKY & et, ecnt});
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int               h, l;
        logic [CNT_W-1:0] c;
        logic             d, t;
        logic [PAT_W-1:0] rpat;
        logic             rovl;
        logic [CNT_W-1:0] rtgt;
        logic [TMO_W-1:0] rtmo;

        vecs[0] = '{"ovl_two_hits", 5'b11011, 1'b1, 8'd2, 16'd0,  32'hFF,  32'hDB,  0, 0, 8'd2, 8'd2, 1'b1, 1'b0, 8};
        vecs[1] = '{"novl_timeout", 5'b11011, 1'b0, 8'd2, 16'd20, 32'hFF,  32'hDB,  0, 0, 8'd1, 8'd1, 1'b0, 1'b1, 20};
        vecs[2] = '{"zero_target",  5'b11011, 1'b1, 8'd0, 16'd0,  32'h0,   32'h0,   0, 0, 8'd0, 8'd0, 1'b1, 1'b0, 0};
        vecs[3] = '{"gapped_valid", 5'b11011, 1'b1, 8'd1, 16'd0,  32'h155, 32'h1EF, 0, 3, 8'd1, 8'd1, 1'b1, 1'b0, 9};
        vecs[4] = '{"hit_on_tmo_t1",5'b11011, 1'b1, 8'd1, 16'd5,  32'h1F,  32'h1B,  0, 0, 8'd1, 8'd1, 1'b1, 1'b0, 5};
        vecs[5] = '{"hit_on_tmo_t2",5'b11011, 1'b1, 8'd2, 16'd5,  32'h1F,  32'h1B,  0, 0, 8'd1, 8'd1, 1'b0, 1'b1, 5};
        vecs[6] = '{"alt_ovl",      5'b10101, 1'b1, 8'd3, 16'd9,  32'h7F,  32'h55,  0, 0, 8'd2, 8'd2, 1'b0, 1'b1, 9};
        vecs[7] = '{"alt_novl",     5'b10101, 1'b0, 8'd3, 16'd9,  32'h7F,  32'h55,  0, 0, 8'd1, 8'd1, 1'b0, 1'b1, 9};
        vecs[8] = '{"abort_on_hit", 5'b11011, 1'b1, 8'd1, 16'd0,  32'h1F,  32'h1B,  5, 0, 8'd0, 8'd0, 1'b0, 1'b0, -1};
        vecs[9] = '{"abort_on_tmo", 5'b11011, 1'b1, 8'd4, 16'd3,  32'h0,   32'h0,   3, 0, 8'd0, 8'd0, 1'b0, 1'b0, -1};

        rst = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; din = 1'b0;
        pattern_cfg = '0; overlap = 1'b0; match_target = '0; timeout_cyc = '0;
        tick();
        tick();
        check_output("reset", {20'd0, pack_obs()}, 32'h0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            load_stim(vecs[i].valid, vecs[i].bits);
            abort_at = vecs[i].abort_at;
            start_at = vecs[i].start_at;
            run_stream(vecs[i].pat, vecs[i].ovl, vecs[i].tgt, vecs[i].tmo, 32, h, c, d, t, l);
            check_output({vecs[i].name, "_result"}, {14'd0, 8'(h), c, d, t},
                         {14'd0, vecs[i].exp_hits, vecs[i].exp_cnt, vecs[i].exp_done, vecs[i].exp_tmo});
            check_output({vecs[i].name, "_len"}, l, vecs[i].exp_len);
        end
        abort_at = 0;
        start_at = 0;

        // Reset in the middle of a run after three bits; the next run must not reuse them.
        pattern_cfg = 5'b11011; overlap = 1'b1; match_target = 8'd1; timeout_cyc = '0;
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1 check_output("async_reset", {20'd0, pack_obs()}, 32'h0);
        tick();
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        load_stim(32'h1F, 32'h1B);
        run_stream(5'b11011, 1'b1, 8'd1, 16'd0, 32, h, c, d, t, l);
        check_output("reset_fresh_result", {14'd0, 8'(h), c, d, t}, {14'd0, 8'd1, 8'd1, 1'b1, 1'b0});
        check_output("reset_fresh_len", l, 5);

        // Done flag after a finished run, then an idle abort.
        load_stim(32'h1F, 32'h1B);
        run_stream(5'b11011, 1'b1, 8'd1, 16'd5, 32, h, c, d, t, l);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        check_output("sticky_hold", {30'd0, done, timeout}, {30'd0, STICKY, 1'b0});
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
        check_output("abort_clears", {30'd0, done, timeout}, 32'h0);
        abort = 1'b0;

        for (int r = 0; r < 40; r++) begin
            rpat = PAT_W'($urandom);
            rovl = 1'($urandom);
            rtgt = CNT_W'($urandom_range(0, 3));
            rtmo = ($urandom_range(0, 3) == 0) ? '0 : TMO_W'($urandom_range(6, 60));
            abort_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 30)) : 0;
            start_at = int'($urandom_range(1, 40));
            for (int i = 0; i < 256; i++) begin
                stim_v[i] = ($urandom_range(0, 3) != 0);
                stim_b[i] = ($urandom_range(0, 2) != 0) ? rpat[PAT_W - 1 - (i % PAT_W)] : 1'($urandom);
            end
            run_stream(rpat, rovl, rtgt, rtmo, 90, h, c, d, t, l);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
